// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage and the register file:
// widths, ppp participation encodings, the WB pipeline payload and the
// ppp-to-bit-mask helper. Bit 0 of the ISA is the MSB, so ISA bits 0:31
// map to [63:32] of a [63:0] vector.
package wb_stage_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned PPP_W  = 3;

    typedef enum logic [PPP_W-1:0] {
        PPP_ALL  = 3'b000,
        PPP_UH   = 3'b001,
        PPP_LH   = 3'b010,
        PPP_EVEN = 3'b011,
        PPP_ODD  = 3'b100
    } ppp_e;

    // Contents of the MEM/WB pipeline register
    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [ADDR_W-1:0] rd;
        logic [PPP_W-1:0]  ppp;
        logic              ld;
        logic [DATA_W-1:0] alu;
    } wb_reg_t;

    // Bits that take new data for a given ppp; reserved codes write all bits
    function automatic logic [DATA_W-1:0] ppp_mask(input logic [PPP_W-1:0] p);
        logic [DATA_W-1:0] m;
        case (p)
            PPP_UH:   m = 64'hFFFF_FFFF_0000_0000;
            PPP_LH:   m = 64'h0000_0000_FFFF_FFFF;
            PPP_EVEN: m = 64'hFF00_FF00_FF00_FF00;
            PPP_ODD:  m = 64'h00FF_00FF_00FF_00FF;
            default:  m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM-side inputs, register-file write port and ID operand bypass of the
// write-back stage. The stage itself uses the slave modport.
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic              mem_valid;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_rd;
    logic [PPP_W-1:0]  mem_ppp;
    logic              mem_is_load;
    logic [DATA_W-1:0] mem_alu_res;
    logic [DATA_W-1:0] dmem_rdata;
    logic              stall;

    logic [ADDR_W-1:0] Wreg;
    logic [DATA_W-1:0] Wdata;
    logic              Wreg_en;
    logic [PPP_W-1:0]  ppp;

    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic [DATA_W-1:0] rf_rs1_data;
    logic [DATA_W-1:0] rf_rs2_data;
    logic [DATA_W-1:0] id_rs1_data;
    logic [DATA_W-1:0] id_rs2_data;

    modport slave (
        input  mem_valid, mem_wr_en, mem_rd, mem_ppp, mem_is_load, mem_alu_res,
        input  dmem_rdata, stall, id_rs1, id_rs2, rf_rs1_data, rf_rs2_data,
        output Wreg, Wdata, Wreg_en, ppp, id_rs1_data, id_rs2_data
    );

    modport master (
        output mem_valid, mem_wr_en, mem_rd, mem_ppp, mem_is_load, mem_alu_res,
        output dmem_rdata, stall, id_rs1, id_rs2, rf_rs1_data, rf_rs2_data,
        input  Wreg, Wdata, Wreg_en, ppp, id_rs1_data, id_rs2_data
    );

endinterface

// File: rtl/wb_stage_ppp_merge.sv
// Merges new write data into an old register value under a ppp mask.
// Only built when WB_BYPASS_EN is defined; otherwise the stage has no merge.
`ifdef WB_BYPASS_EN
module wb_stage_ppp_merge
    import wb_stage_pkg::*;
(
    input  logic [DATA_W-1:0] new_data,
    input  logic [DATA_W-1:0] old_data,
    input  logic [PPP_W-1:0]  ppp,
    output logic [DATA_W-1:0] merged_c
);

    logic [DATA_W-1:0] mask;

    // Participating bits from new data, the rest from old data
    always_comb begin
        mask     = ppp_mask(ppp);
        merged_c = (new_data & mask) | (old_data & ~mask);
    end

endmodule
`endif

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load/ALU write-data select with a
// hold register for late load data, register-file write port and ID operand
// bypass. Macro WB_BYPASS_EN builds the ppp-merged bypass; without it the
// operands pass straight from the register file (R0 still reads 0).
module wb_stage
    import wb_stage_pkg::*;
(
    input logic        clk,
    input logic        rst_n,
    wb_stage_if.slave  bus
);

    wb_reg_t           wb_q;
    logic              wb_first;
    logic [DATA_W-1:0] ld_hold;
    logic [DATA_W-1:0] wdata_c;
    logic              wen_c;

    // WB register capture; on stall hold fields and latch one-cycle load data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q     <= '0;
            wb_first <= 1'b0;
            ld_hold  <= '0;
        end else if (!bus.stall) begin
            wb_q.valid <= bus.mem_valid;
            wb_q.wen   <= bus.mem_wr_en;
            wb_q.rd    <= bus.mem_rd;
            wb_q.ppp   <= bus.mem_ppp;
            wb_q.ld    <= bus.mem_is_load;
            wb_q.alu   <= bus.mem_alu_res;
            wb_first   <= 1'b1;
        end else begin
            wb_first <= 1'b0;
            if (wb_first) begin
                ld_hold <= bus.dmem_rdata;
            end
        end
    end

    // Write data and enable; R0 is never written
    always_comb begin
        wdata_c = wb_q.alu;
        if (wb_q.ld) begin
            wdata_c = wb_first ? bus.dmem_rdata : ld_hold;
        end
        wen_c = wb_q.valid & wb_q.wen & (wb_q.rd != '0);
    end

    assign bus.Wreg    = wb_q.rd;
    assign bus.Wdata   = wdata_c;
    assign bus.Wreg_en = wen_c;
    assign bus.ppp     = wb_q.ppp;

`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] merged1_c;
    logic [DATA_W-1:0] merged2_c;

    wb_stage_ppp_merge u_merge1 (
        .new_data (wdata_c),
        .old_data (bus.rf_rs1_data),
        .ppp      (wb_q.ppp),
        .merged_c (merged1_c)
    );

    wb_stage_ppp_merge u_merge2 (
        .new_data (wdata_c),
        .old_data (bus.rf_rs2_data),
        .ppp      (wb_q.ppp),
        .merged_c (merged2_c)
    );

    // Operand select: R0, in-flight WB write, or register file
    always_comb begin
        bus.id_rs1_data = bus.rf_rs1_data;
        bus.id_rs2_data = bus.rf_rs2_data;
        if (bus.id_rs1 == '0) begin
            bus.id_rs1_data = '0;
        end else if (wen_c && (bus.id_rs1 == wb_q.rd)) begin
            bus.id_rs1_data = merged1_c;
        end
        if (bus.id_rs2 == '0) begin
            bus.id_rs2_data = '0;
        end else if (wen_c && (bus.id_rs2 == wb_q.rd)) begin
            bus.id_rs2_data = merged2_c;
        end
    end
`else
    // Operand select without bypass: the hazard unit covers RAW with WB
    always_comb begin
        bus.id_rs1_data = (bus.id_rs1 == '0) ? '0 : bus.rf_rs1_data;
        bus.id_rs2_data = (bus.id_rs2 == '0) ? '0 : bus.rf_rs2_data;
    end
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the Cardinal pipeline. Sits between the MEM stage / data memory and the 32x64 register file.
- Holds the MEM/WB pipeline register and selects the write data: ALU result, or load data that arrives one cycle late.
- Drives the register-file write port (Wreg, Wdata, Wreg_en, ppp).
- Supplies ID with bypassed, ppp-merged operands, because the register file does not return same-cycle write data on its asynchronous reads.

Parameters:
- DATA_W, 64, datapath width. Bit 0 is MSB, matching the ISA.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_wr_en  in  1  instruction writes a register
- mem_rd  in  ADDR_W  destination register
- mem_ppp  in  3  participation field
- mem_is_load  in  1  write data comes from data memory
- mem_alu_res  in  DATA_W  ALU result
- dmem_rdata  in  DATA_W  data-memory read data; valid only in the first cycle the load is in WB
- stall  in  1  freeze the WB register
- Wreg  out  ADDR_W  register-file write address
- Wdata  out  DATA_W  register-file write data
- Wreg_en  out  1  register-file write enable
- ppp  out  3  register-file participation field
- id_rs1, id_rs2  in  ADDR_W  ID read addresses (also driven to the register file)
- rf_rs1_data, rf_rs2_data  in  DATA_W  register-file read data
- id_rs1_data, id_rs2_data  out  DATA_W  bypassed operands to ID

Behaviour:
- Reset (rst_n low, asynchronous):
  - All WB registers, first-cycle flag and load-hold register clear to 0.
  - Outputs read Wreg_en=0, Wreg=0, Wdata=0, ppp=000.
  - A write pending at reset is dropped.
- Capture, at posedge with stall=0:
  - wb_valid<=mem_valid; wb_wen<=mem_wr_en; wb_rd<=mem_rd; wb_ppp<=mem_ppp; wb_ld<=mem_is_load; wb_alu<=mem_alu_res; wb_first<=1.
- Stall, at posedge with stall=1:
  - All WB fields hold.
  - wb_first<=0.
  - If wb_first was 1, ld_hold<=dmem_rdata.
- Write data:
  - Wdata = wb_ld ? (wb_first ? dmem_rdata : ld_hold) : wb_alu.
  - Outputs are combinational from the WB register.
- Write enable:
  - Wreg_en = wb_valid & wb_wen & (wb_rd!=0). Wreg=wb_rd; ppp=wb_ppp.
  - R0 is never written.
- Latency: an instruction captured at edge N is written into the register file at edge N+1. Each extra stall cycle adds one edge.
- Stall with a pending write: Wreg_en stays asserted and the same value is re-written every stalled cycle (idempotent). After the first cycle, load data comes from ld_hold, so a changing dmem_rdata has no effect.
- ppp mask, using big-endian bit indices:
  - 000: all bits
  - 001: 0:31
  - 010: 32:63
  - 011: bytes 0,2,4,6 (0:7, 16:23, 32:39, 48:55)
  - 100: bytes 1,3,5,7 (8:15, 24:31, 40:47, 56:63)
  - 101-111: treated as 000
- Bypass, per operand, combinational:
  - If rsX==0: output 0.
  - Else if Wreg_en & rsX==wb_rd: output (Wdata & mask) | (rf_rsX_data & ~mask).
  - Else: output rf_rsX_data.
  - Bypass is active during stall.
- No internal state machine beyond the first/hold phase. Phases: EMPTY (wb_valid=0) -> FIRST (wb_first=1) -> HELD (wb_first=0, stalled). Capture from any phase returns to FIRST, or to EMPTY if mem_valid=0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: bypass as above.
- Undefined: id_rsX_data = (rsX==0) ? 0 : rf_rsX_data. No comparators or merge logic are built. The hazard unit must then stall ID for one cycle on an RAW hit with WB.

Decomposition:
- Shared package: ppp encodings (PPP_ALL, PPP_UH, PPP_LH, PPP_EVEN, PPP_ODD), DATA_W/ADDR_W constants, and a ppp-to-64-bit mask function. The register file uses the same function.
- One natural sub-module, ppp_merge (inputs: new data, old data, ppp; output: merged data). It is instantiated twice for the two bypass operands.

Test Plan:
- ALU write:
  - Stimulus: mem_valid=1, wr_en=1, rd=5, ppp=000, alu=64'h0123_4567_89AB_CDEF, captured at edge N.
  - Response: Wreg_en=1, Wreg=5 and Wdata=alu during cycle N..N+1; Wreg_en=0 after the next capture with mem_valid=0.
- R0 and reset:
  - Stimulus: rd=0 with wr_en=1.
  - Response: Wreg_en=0, id_rs1_data=0 for rs1=0.
  - Stimulus: assert rst_n=0 mid-write.
  - Response: Wreg_en drops immediately, Wdata=0.
- Load plus stall:
  - Stimulus: load to rd=7; dmem_rdata=64'hAAAA_BBBB_CCCC_DDDD in the first WB cycle, then 64'h0; stall=1 for 2 cycles.
  - Response: Wdata stays AAAA_BBBB_CCCC_DDDD for all 3 cycles, with Wreg_en=1 throughout.
- Bypass merge, ppp=011:
  - Stimulus: Wdata=64'hFFFF_FFFF_FFFF_FFFF, rf_rs2_data=0, rs2=rd=9.
  - Response: id_rs2_data=64'hFF00_FF00_FF00_FF00.
- Bypass merge, other ppp values:
  - ppp=100 -> 64'h00FF_00FF_00FF_00FF.
  - ppp=001 -> 64'hFFFF_FFFF_0000_0000.
  - ppp=110 -> full 64'hFFFF_FFFF_FFFF_FFFF.
- WB_BYPASS_EN undefined:
  - Stimulus: same stimulus as the ppp=011 bypass case.
  - Response: id_rs2_data=rf_rs2_data=0.
